// File: rtl/approx_mul_dot_accumulator.sv
// Dot-product accumulator for a stream of approximate-multiplier products.
// Optional build macro ACC_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module approx_mul_dot_accumulator #(
    parameter int PROD_W  = 16,
    parameter int VEC_LEN = 8,
    parameter int ACC_W   = 19,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               accept;
    logic               terminal;
    logic [ACC_W:0]     sum_ext;
    logic               carry;

    // in_ready is forced low while reset is asserted so nothing is taken during reset.
    assign in_ready = rst_n && (state_q != DONE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_ext = (ACC_W+1)'(in_prod);
        if (state_q == ACC)
            sum_ext = {1'b0, acc_q} + (ACC_W+1)'(in_prod);
        carry = sum_ext[ACC_W];
    end

    always_comb begin
        terminal = in_last;
        if (state_q == IDLE && VEC_LEN == 1)
            terminal = 1'b1;
        if (state_q == ACC && count_q == CNT_W'(VEC_LEN - 1))
            terminal = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACC: if (accept) state_d = terminal ? DONE : ACC;
            DONE:      if (out_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Output logic: results are only exposed while DONE
    always_comb begin
        out_valid = (state_q == DONE);
        out_sum   = out_valid ? acc_q   : '0;
        out_count = out_valid ? count_q : '0;
        out_ovf   = out_valid ? ovf_q   : 1'b0;
    end

    always_comb begin
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (accept) begin
            count_d = (state_q == IDLE) ? CNT_W'(1) : count_q + CNT_W'(1);
            ovf_d   = ovf_q | carry;
`ifdef ACC_SAT_EN
            // Once saturated, stay pinned at full scale for the rest of the vector.
            acc_d   = (carry || ovf_q) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
            acc_d   = sum_ext[ACC_W-1:0];
`endif
        end else if (state_q == DONE && out_ready) begin
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_approx_mul_dot_accumulator.sv
// Bench: table vectors, hand sequences and random vectors against an arithmetic model.
module tb_approx_mul_dot_accumulator;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       in_valid = '0, in_last = '0, out_ready = '0;
    logic [1:0]       in_ready, out_valid, out_ovf;
    logic [1:0][15:0] in_prod = '0;
    logic [1:0][3:0]  out_count;
    logic [18:0]      sum0;
    logic [16:0]      sum1;
    int               nvec = 0, nerr = 0;

    always #5 clk = ~clk;

    approx_mul_dot_accumulator u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_prod(in_prod[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(sum0), .out_count(out_count[0]), .out_ovf(out_ovf[0]));

    approx_mul_dot_accumulator #(.ACC_W(17)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_prod(in_prod[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(sum1), .out_count(out_count[1]), .out_ovf(out_ovf[1]));

    function automatic longint osum(int d);
        return d ? longint'(sum1) : longint'(sum0);
    endfunction

    // Reference: true sum of the vector, reduced to the accumulator width.
    function automatic void ref_model(input longint tot, input int accw,
                                      output longint es, output bit eo);
        longint mx;
        mx = (longint'(1) << accw) - 1;
        eo = tot > mx;
`ifdef ACC_SAT_EN
        es = eo ? mx : tot;
`else
        es = tot & mx;
`endif
    endfunction

    task automatic chk(string nm, longint act, longint exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Starts and ends on a negedge; holds the product until accepted.
    task automatic send(int d, logic [15:0] p, bit last);
        int n = 0;
        in_valid[d] = 1'b1; in_prod[d] = p; in_last[d] = last;
        while (!in_ready[d] && n < 40) begin @(negedge clk); n++; end
        if (!in_ready[d]) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: in_ready stuck at 0 on dut %0d", d);
        end
        @(posedge clk); @(negedge clk);
        in_valid[d] = 1'b0;
        in_prod[d]  = 16'($urandom);
        in_last[d]  = 1'($urandom);
    endtask

    task automatic collect(int d, string nm, longint es, longint ec, bit eo, output int waited);
        waited = 0;
        while (!out_valid[d] && waited < 40) begin @(negedge clk); waited++; end
        chk({nm, "_valid"}, out_valid[d], 1);
        chk({nm, "_sum"}, osum(d), es);
        chk({nm, "_count"}, out_count[d], ec);
        chk({nm, "_ovf"}, out_ovf[d], eo);
        chk({nm, "_inready_done"}, in_ready[d], 0);
        out_ready[d] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[d] = 1'b0;
        chk({nm, "_cleared"}, out_valid[d], 0);
    endtask

    typedef struct {
        string       nm;
        int          len;
        logic [15:0] p[8];
        bit          lastf;
        bit          gap;
        longint      exp_sum;
        longint      exp_cnt;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int     w;
        longint tot, es;
        bit     eo;

        tbl[0] = '{"full_fe01", 8, '{16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01,
                   16'hFE01, 16'hFE01, 16'hFE01, 16'hFE01}, 1'b0, 1'b0, 520200, 8};
        tbl[1] = '{"short3", 3, '{100, 200, 300, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 600, 3};
        tbl[2] = '{"gapped", 8, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b0, 1'b1, 36, 8};
        tbl[3] = '{"last_at_term", 8, '{1, 2, 3, 4, 5, 6, 7, 8}, 1'b1, 1'b0, 36, 8};
        tbl[4] = '{"single", 1, '{16'hFFFF, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 65535, 1};
        tbl[5] = '{"zeros", 2, '{0, 0, 0, 0, 0, 0, 0, 0}, 1'b1, 1'b0, 0, 2};

        #3;
        chk("rst_valid", out_valid[0], 0);
        chk("rst_sum", sum0, 0);
        chk("rst_count", out_count[0], 0);
        chk("rst_ovf", out_ovf[0], 0);
        chk("rst_inready", in_ready[0], 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_inready", in_ready[0], 1);

        for (int i = 0; i < 6; i++) begin
            for (int k = 0; k < tbl[i].len; k++) begin
                send(0, tbl[i].p[k], tbl[i].lastf && (k == tbl[i].len - 1));
                if (tbl[i].gap && k != tbl[i].len - 1) begin
                    chk({tbl[i].nm, "_gap_valid"}, out_valid[0], 0);
                    chk({tbl[i].nm, "_gap_sum"}, sum0, 0);
                    @(negedge clk);
                end
            end
            collect(0, tbl[i].nm, tbl[i].exp_sum, tbl[i].exp_cnt, 1'b0, w);
            chk({tbl[i].nm, "_latency"}, w, 0);
            chk({tbl[i].nm, "_single_done"}, out_valid[0], 0);
        end

        // Stall with out_ready low, then check the one-bubble restart.
        for (int k = 0; k < 8; k++) send(0, 16'hFE01, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("stall_valid", out_valid[0], 1);
            chk("stall_sum", sum0, 520200);
            chk("stall_count", out_count[0], 8);
            chk("stall_inready", in_ready[0], 0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1; in_prod[0] = 16'd5; in_last[0] = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready[0] = 1'b0;
        chk("restart_valid_low", out_valid[0], 0);
        chk("restart_inready", in_ready[0], 1);
        @(posedge clk); @(negedge clk);
        in_valid[0] = 1'b0; in_last[0] = 1'b0;
        collect(0, "restart", 5, 1, 1'b0, w);

        // Overflow on the 17-bit instance.
        for (int k = 0; k < 3; k++) send(1, 16'hFE01, k == 2);
        ref_model(3 * 65025, 17, es, eo);
`ifdef ACC_SAT_EN
        chk("ovf17_model", es, 131071);
`else
        chk("ovf17_model", es, 64003);
`endif
        collect(1, "ovf17", es, 3, eo, w);

        // Reset mid-vector and with a pending result.
        for (int k = 0; k < 4; k++) send(0, 16'd1000, 1'b0);
        rst_n = 1'b0; #1;
        chk("midrst_valid", out_valid[0], 0);
        chk("midrst_inready", in_ready[0], 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        send(0, 16'd9, 1'b1);
        chk("pend_valid", out_valid[0], 1);
        rst_n = 1'b0; #1;
        chk("pendrst_valid", out_valid[0], 0);
        chk("pendrst_sum", sum0, 0);
        @(negedge clk); rst_n = 1'b1; @(negedge clk);
        send(0, 16'd7, 1'b0);
        send(0, 16'd7, 1'b1);
        collect(0, "after_rst", 14, 2, 1'b0, w);

        // Random vectors on both instances.
        for (int it = 0; it < 40; it++) begin
            int d, len;
            bit lastf;
            d = it % 2;
            len = $urandom_range(1, 8);
            lastf = (len < 8) ? 1'b1 : 1'($urandom);
            tot = 0;
            for (int k = 0; k < len; k++) begin
                logic [15:0] p;
                p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
                tot += p;
                send(d, p, lastf && (k == len - 1));
                if ($urandom_range(0, 2) == 0 && k != len - 1) @(negedge clk);
            end
            ref_model(tot, d ? 17 : 19, es, eo);
            collect(d, $sformatf("rand%0d", it), es, len, eo, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
